sprite_mem_arbiter: RTL and testbench



---
 rtl/sprite_mem_arbiter_pkg.sv | 17 +
 rtl/sprite_wbuf_fifo.sv | 62 ++++++
 rtl/sprite_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_sprite_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mem_arbiter_pkg.sv
// Shared sizing, grant encoding and write-buffer entry type for the sprite memory arbiter.
package sprite_mem_arbiter_pkg;
  localparam int SPRITE_NUM           = 8;
  localparam int SPRITE_ADDR_SIZE     = 9;
  localparam int SEL_W                = $clog2(SPRITE_NUM);
  localparam int ADDR_W               = SPRITE_ADDR_SIZE + 1;
  localparam int WBUF_DEPTH_DEFAULT   = 4;
  localparam int ARB_MAX_WAIT_DEFAULT = 8;

  typedef enum logic [1:0] {GNT_NONE, GNT_READ, GNT_WRITE} grant_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sprite;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wbuf_entry_t;
endpackage

// File: rtl/sprite_wbuf_fifo.sv
// Small synchronous FIFO buffering SPI sprite writes; a push on a full FIFO is rejected
// even when a pop happens in the same cycle.
module sprite_wbuf_fifo
  import sprite_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  wbuf_entry_t push_entry,
  output wbuf_entry_t head,
  output logic        full,
  output logic        empty
);
  localparam int PTR_W = $clog2(DEPTH);

  wbuf_entry_t      entries_q [DEPTH];
  wbuf_entry_t      entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = entries_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push) begin
      entries_d[wr_ptr_q] = push_entry;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: rtl/sprite_mem_arbiter.sv
// Shares the single-port sprite memory between buffered SPI writes and renderer reads;
// reads win, but a non-empty write buffer is never denied more than MAX_WAIT cycles in a row.
module sprite_mem_arbiter
  import sprite_mem_arbiter_pkg::*;
#(
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT,
  parameter int MAX_WAIT   = ARB_MAX_WAIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [SEL_W-1:0]  wr_sprite,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              wr_overflow,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sprite,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_sprite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              idle
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  wbuf_entry_t       fifo_head, fifo_in;
  logic              fifo_full, fifo_empty;
  grant_e            grant;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              wr_overflow_q, wr_overflow_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [SEL_W-1:0]  mem_sprite_q, mem_sprite_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;

  assign fifo_in = '{sprite: wr_sprite, addr: wr_addr, data: wr_data};

  sprite_wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clock      (clock),
    .reset      (reset),
    .push       (wr_valid),
    .pop        (grant == GNT_WRITE),
    .push_entry (fifo_in),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Grant is gated by reset so rd_ack reads 0 while reset is held.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (!fifo_empty && (!rd_req || starve_q == MAX_WAIT_C)) begin
        grant = GNT_WRITE;
      end else if (rd_req) begin
        grant = GNT_READ;
      end
    end
  end

  always_comb begin
    wr_overflow_d = wr_overflow_q | (wr_valid & fifo_full);
    starve_d      = starve_q;
    if (fifo_empty || grant == GNT_WRITE) begin
      starve_d = '0;
    end else if (grant == GNT_READ && starve_q != MAX_WAIT_C) begin
      starve_d = starve_q + 1'b1;
    end

    mem_en_d     = (grant != GNT_NONE);
    mem_we_d     = (grant == GNT_WRITE);
    mem_sprite_d = mem_sprite_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (grant)
      GNT_WRITE: begin
        mem_sprite_d = fifo_head.sprite;
        mem_addr_d   = fifo_head.addr;
        mem_wdata_d  = fifo_head.data;
      end
      GNT_READ: begin
        mem_sprite_d = rd_sprite;
        mem_addr_d   = rd_addr;
      end
      default: ;
    endcase

    // The memory answers one cycle after the read is on the bus.
    rd_pend_d  = (grant == GNT_READ);
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_valid_q ? mem_rdata : rd_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q      <= '0;
      wr_overflow_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_sprite_q  <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      starve_q      <= starve_d;
      wr_overflow_q <= wr_overflow_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_sprite_q  <= mem_sprite_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign wr_ready    = ~fifo_full;
  assign wr_overflow = wr_overflow_q;
  assign rd_ack      = (grant == GNT_READ);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_valid_q ? mem_rdata : rd_data_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_sprite  = mem_sprite_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign idle        = fifo_empty & ~mem_en_q & ~rd_pend_q;
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: directed vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based reference model and a byte-array memory.
module tb_sprite_mem_arbiter;
  import sprite_mem_arbiter_pkg::*;

  localparam int DEPTH = WBUF_DEPTH_DEFAULT;
  localparam int MAXW  = ARB_MAX_WAIT_DEFAULT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0, rd_req = 1'b0;
  logic [2:0] wr_sprite = '0, rd_sprite = '0;
  logic [9:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic wr_ready, wr_overflow, rd_ack, rd_valid, mem_en, mem_we, idle;
  logic [7:0] rd_data, mem_wdata, mem_rdata;
  logic [2:0] mem_sprite;
  logic [9:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sprite_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_sprite(wr_sprite), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_overflow(wr_overflow),
    .rd_req(rd_req), .rd_sprite(rd_sprite), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sprite(mem_sprite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .idle(idle)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pattern(input logic [12:0] a);
    return a[7:0] ^ 8'h38;
  endfunction

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  bit [7:0] ram [8192];
  bit       ram_wr [8192];
  logic [12:0] sidx;
  assign sidx = {mem_sprite, mem_addr};
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[sidx]    <= mem_wdata;
        ram_wr[sidx] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[sidx] ? ram[sidx] : pattern(sidx);
      end
    end
  end

  // Reference model state
  wbuf_entry_t mq[$];
  wbuf_entry_t wlog[$];
  int   m_starve = 0;
  bit   m_ovf = 0, m_en = 0, m_we = 0, m_rv = 0;
  logic [2:0] m_sp = '0;
  logic [9:0] m_addr = '0;
  logic [7:0] m_wd = '0, m_rd = '0;
  bit [7:0] mref [8192];
  bit       mwr [8192];

  logic s_ack, s_ready, s_ovf, s_en, s_we, s_rv, s_idle;
  logic [2:0] s_sp;
  logic [9:0] s_addr;
  logic [7:0] s_wd, s_rd;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    int sz;
    bit gw, gr, nxt_rv;
    logic [12:0] idx;
    wbuf_entry_t e;
    @(negedge clock);
    sz = mq.size();
    gw = !reset && sz > 0 && (!rd_req || m_starve == MAXW);
    gr = !reset && !gw && rd_req;
    s_ack = rd_ack; s_ready = wr_ready; s_ovf = wr_overflow; s_en = mem_en; s_we = mem_we;
    s_rv = rd_valid; s_idle = idle; s_sp = mem_sprite; s_addr = mem_addr; s_wd = mem_wdata;
    s_rd = rd_data;
    checkOutput("rd_ack", 32'(s_ack), 32'(gr));
    checkOutput("wr_ready", 32'(s_ready), 32'(sz < DEPTH));
    checkOutput("wr_overflow", 32'(s_ovf), 32'(m_ovf));
    checkOutput("mem_en", 32'(s_en), 32'(m_en));
    checkOutput("mem_we", 32'(s_we), 32'(m_we));
    checkOutput("mem_sprite", 32'(s_sp), 32'(m_sp));
    checkOutput("mem_addr", 32'(s_addr), 32'(m_addr));
    checkOutput("mem_wdata", 32'(s_wd), 32'(m_wd));
    checkOutput("rd_valid", 32'(s_rv), 32'(m_rv));
    checkOutput("rd_data", 32'(s_rd), 32'(m_rd));
    checkOutput("idle", 32'(s_idle), 32'(sz == 0 && !m_en));
    if (mem_en && mem_we) wlog.push_back('{sprite: mem_sprite, addr: mem_addr, data: mem_wdata});

    idx = {m_sp, m_addr};
    nxt_rv = m_en && !m_we;
    if (m_en && m_we) begin
      mref[idx] = m_wd;
      mwr[idx] = 1'b1;
    end
    if (nxt_rv) m_rd = mwr[idx] ? mref[idx] : pattern(idx);
    m_rv = nxt_rv;
    if (reset) begin
      mq.delete();
      m_starve = 0; m_ovf = 0; m_en = 0; m_we = 0; m_rv = 0;
      m_sp = '0; m_addr = '0; m_wd = '0; m_rd = '0;
    end else begin
      if (sz == 0 || gw) m_starve = 0;
      else if (gr && m_starve < MAXW) m_starve++;
      m_en = gw || gr;
      m_we = gw;
      if (gw) begin
        e = mq.pop_front();
        m_sp = e.sprite; m_addr = e.addr; m_wd = e.data;
      end else if (gr) begin
        m_sp = rd_sprite; m_addr = rd_addr;
      end
      if (wr_valid) begin
        if (sz < DEPTH) mq.push_back('{sprite: wr_sprite, addr: wr_addr, data: wr_data});
        else m_ovf = 1;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit wv, input logic [2:0] ws, input logic [9:0] wa,
                               input logic [7:0] wd, input bit rq, input logic [2:0] rs,
                               input logic [9:0] ra);
    wr_valid = wv; wr_sprite = ws; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_sprite = rs; rd_addr = ra;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
    reset = 1'b0;
    wlog.delete();
  endtask

  typedef struct {
    bit rst; bit wv; logic [2:0] ws; logic [9:0] wa; logic [7:0] wd;
    bit rq; logic [2:0] rs; logic [9:0] ra;
    bit e_ack; bit e_en; bit e_we; logic [2:0] e_sp; logic [9:0] e_addr;
    logic [7:0] e_wd; bit e_rv; logic [7:0] e_rd; bit e_idle;
  } vec_t;

  vec_t vec [12];
  int   gaps[$];
  int   rv_seen;

  initial begin
    vec[0]  = '{1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 8'h00, 0, 8'h00, 1};
    vec[1]  = '{0, 1, 2, 10'h010, 8'hA5, 0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 8'h00, 0, 8'h00, 1};
    vec[2]  = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 8'h00, 0, 8'h00, 0};
    vec[3]  = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 1, 1, 2, 10'h010, 8'hA5, 0, 8'h00, 0};
    vec[4]  = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 0, 0, 2, 10'h010, 8'hA5, 0, 8'h00, 1};
    vec[5]  = '{0, 0, 0, 10'h000, 8'h00, 1, 0, 10'h004, 1, 0, 0, 2, 10'h010, 8'hA5, 0, 8'h00, 1};
    vec[6]  = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 1, 0, 0, 10'h004, 8'hA5, 0, 8'h00, 0};
    vec[7]  = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 0, 0, 0, 10'h004, 8'hA5, 1, 8'h3C, 1};
    vec[8]  = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 0, 0, 0, 10'h004, 8'hA5, 0, 8'h3C, 1};
    vec[9]  = '{0, 0, 0, 10'h000, 8'h00, 1, 2, 10'h010, 1, 0, 0, 0, 10'h004, 8'hA5, 0, 8'h3C, 1};
    vec[10] = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 1, 0, 2, 10'h010, 8'hA5, 0, 8'h3C, 0};
    vec[11] = '{0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 0, 0, 0, 2, 10'h010, 8'hA5, 1, 8'hA5, 1};

    doReset(2);
    for (int i = 0; i < 12; i++) begin
      reset = vec[i].rst;
      applyStimulus(vec[i].wv, vec[i].ws, vec[i].wa, vec[i].wd, vec[i].rq, vec[i].rs, vec[i].ra);
      step();
      checkOutput("vec_ack", 32'(s_ack), 32'(vec[i].e_ack));
      checkOutput("vec_en", 32'(s_en), 32'(vec[i].e_en));
      checkOutput("vec_we", 32'(s_we), 32'(vec[i].e_we));
      checkOutput("vec_sprite", 32'(s_sp), 32'(vec[i].e_sp));
      checkOutput("vec_addr", 32'(s_addr), 32'(vec[i].e_addr));
      checkOutput("vec_wdata", 32'(s_wd), 32'(vec[i].e_wd));
      checkOutput("vec_rvalid", 32'(s_rv), 32'(vec[i].e_rv));
      checkOutput("vec_rdata", 32'(s_rd), 32'(vec[i].e_rd));
      checkOutput("vec_idle", 32'(s_idle), 32'(vec[i].e_idle));
    end
    reset = 1'b0;

    // Starvation: continuous reads, three buffered writes get one slot every MAXW+1 cycles
    doReset(2);
    gaps.delete();
    for (int c = 0; c < 36; c++) begin
      applyStimulus(c < 3, 3'(c), 10'(10'h100 + c), 8'(8'h10 + c), 1, 3'd1, 10'(c));
      step();
      if (!s_ack) gaps.push_back(c);
    end
    checkOutput("starve_slots", 32'(gaps.size()), 32'd3);
    for (int k = 0; k < gaps.size() && k < 3; k++)
      checkOutput("starve_slot_cycle", 32'(gaps[k]), 32'((MAXW + 1) * (k + 1)));
    checkOutput("starve_wr_count", 32'(wlog.size()), 32'd3);
    for (int k = 0; k < wlog.size() && k < 3; k++)
      checkOutput("starve_wr_order", 32'(wlog[k].data), 32'(8'h10 + k));

    // Overflow: five pushes into a four-entry buffer while reads hog the port
    doReset(2);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(c < 5, 3'd3, 10'(10'h200 + c), 8'(8'h40 + c), 1, 3'd0, 10'h3FF);
      step();
      if (c == 3) checkOutput("ovf_ready_before", 32'(s_ready), 32'd1);
      if (c == 4) checkOutput("ovf_ready_full", 32'(s_ready), 32'd0);
      if (c == 5) checkOutput("ovf_sticky_set", 32'(s_ovf), 32'd1);
    end
    checkOutput("ovf_wr_count", 32'(wlog.size()), 32'd4);
    checkOutput("ovf_still_set", 32'(s_ovf), 32'd1);
    doReset(2);
    checkOutput("ovf_cleared", 32'(s_ovf), 32'd0);

    // Push and pop together with two entries buffered
    applyStimulus(1, 3'd4, 10'h020, 8'hA1, 1, 3'd0, 10'h000); step();
    applyStimulus(1, 3'd4, 10'h021, 8'hA2, 1, 3'd0, 10'h001); step();
    applyStimulus(1, 3'd4, 10'h022, 8'hA3, 0, 3'd0, 10'h000); step();
    checkOutput("pp_ready_same", 32'(s_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("pp_ready_after", 32'(s_ready), 32'd1);
    repeat (5) step();
    checkOutput("pp_wr_count", 32'(wlog.size()), 32'd3);
    for (int k = 0; k < wlog.size() && k < 3; k++)
      checkOutput("pp_wr_order", 32'(wlog[k].data), 32'(8'hA1 + k));

    // Reset lands the cycle after a read grant, with writes still buffered
    doReset(2);
    applyStimulus(1, 3'd5, 10'h030, 8'hC1, 1, 3'd6, 10'h001); step();
    applyStimulus(1, 3'd5, 10'h031, 8'hC2, 1, 3'd6, 10'h002); step();
    applyStimulus(0, 0, 0, 0, 1, 3'd6, 10'h003); step();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    wlog.delete();
    rv_seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 0) checkOutput("rst_idle", 32'(s_idle), 32'd1);
      if (s_rv) rv_seen++;
    end
    checkOutput("rst_no_rvalid", 32'(rv_seen), 32'd0);
    checkOutput("rst_no_writes", 32'(wlog.size()), 32'd0);

    // Random traffic against the reference model
    doReset(2);
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 15)),
                    8'($urandom), $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)),
                    10'($urandom_range(0, 15)));
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
